bp_be_dual_issue_sched: RTL and testbench
=========================================

Name: bp_be_dual_issue_sched

Overview:
In-order dual-issue pairing controller for the BE checker stage. Accepts decoded instruction pairs, holds them in a 2-slot issue buffer and tracks in-flight long-latency destinations in an internal pending-register scoreboard. Each cycle it issues both slots, slot 0 only, or nothing, based on RAW/WAW and long-pipe structural hazards. It sits between decode and the dispatch/pipe-select logic.

Parameters:
bp_params_p, e_bp_default_cfg, processor config; supplies reg_addr_width_gp (5) and instr_width_gp (32).
stall_cnt_width_p, 16, width of the saturating stall-cycle counter.

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
flush_i  in  1  drop all buffered (unissued) instructions
pair_v_i  in  1  incoming pair valid (slot 0 must be valid when high)
pair_ready_o  out  1  pair accepted when pair_v_i & pair_ready_o
in_v_i  in  2  per-slot valid; [1] may be 0 (single instruction)
in_instr_i  in  2x instr_width_gp  per-slot instruction payload
in_rs1_i, in_rs2_i  in  2x5 each  per-slot source registers
in_rs1_r_v_i, in_rs2_r_v_i  in  2 each  per-slot source-read valid
in_rd_i  in  2x5  per-slot destination
in_rd_w_v_i  in  2  per-slot destination-write valid
in_long_i  in  2  per-slot long-latency class (mul/div/mem/fp)
clear_v_i  in  1  long-latency writeback valid
clear_rd_i  in  5  writeback destination
issue_v_o  out  2  slot issues this cycle; [1] implies [0]
issue_instr_o  out  2x instr_width_gp  issued payload
stall_cnt_o  out  stall_cnt_width_p  cycles with a buffered instr and no issue

Behaviour:
- Register file index space 2**reg_addr_width_gp; x0 is never pending and never causes a hazard.
- Buffer FSM states: EMPTY, PAIR (slots 0,1 held), SINGLE (one instr held in slot 0).
- An accepted pair loads the buffer in cycle N; it becomes issue-eligible in N+1, so minimum latency is 1 cycle. A single (in_v_i=2'b01) loads as SINGLE.
- Slot-0 hazard: a valid source read of a pending reg, or rd_w_v with rd pending (WAW).
- Slot-1 hazard (PAIR only): its own slot-0-style hazard; OR reads slot 0's rd while slot 0 has rd_w_v and rd!=0; OR WAW with slot 0's rd; OR both slots in_long (one long pipe).
- issue_v_o[0] = buffered & no slot-0 hazard. issue_v_o[1] = PAIR & issue_v_o[0] & no slot-1 hazard. Issue is strictly in order.
- Transitions: PAIR with both issued -> EMPTY (or reload). PAIR with slot 0 only -> SINGLE, and the slot-1 contents shift to slot 0. Nothing issued -> state held. SINGLE issued -> EMPTY (or reload).
- pair_ready_o = ~reset_i & ~flush_i & (EMPTY | every held slot issues this cycle). Acceptance and a same-cycle issue of the last held slot are both allowed.
- Scoreboard: a bit is set on issue of a slot with in_long, rd_w_v and rd!=0, and cleared by clear_v_i/clear_rd_i. Set wins over clear on the same reg in the same cycle. Hazard checks read only the registered bits, so a clear takes effect the next cycle (no same-cycle bypass).
- Two slots never set the same reg in one cycle, because the WAW rule prevents it.
- flush_i: buffer -> EMPTY next cycle and issue_v_o is forced 0 that cycle. Scoreboard bits are retained, since outstanding writebacks still return.
- stall_cnt_o increments in cycles where state != EMPTY and issue_v_o == 0. It saturates at all-ones and is not cleared by flush.
- Reset: state EMPTY, scoreboard all 0, stall_cnt_o 0, issue_v_o 0, pair_ready_o 0 during reset and 1 the cycle after.
- A reset asserted mid-operation discards the buffer and scoreboard with no writeback accounting.

Test Plan:
- Independent pair (add x1,x2,x3 ; add x4,x5,x6), empty scoreboard -> issue_v_o=2'b11 one cycle after accept; pair_ready_o stays 1 for back-to-back pairs.
- Intra-pair RAW (add x1.. ; sub x7,x1,x2) -> cycle 1 issue_v_o=2'b01, state SINGLE; cycle 2 issue_v_o=2'b01 carrying the sub payload; pair_ready_o=1 in cycle 2.
- Long-latency load x5 issued, then pair reading x5 -> issue_v_o=0 and stall_cnt_o increments each cycle. Assert clear_v_i with clear_rd_i=5 in cycle K -> issue occurs in cycle K+1.
- Two long ops in one pair (mul x1 ; div x2) -> slot 1 is held one cycle and its x1 pending bit does not block it. Clear of x1 and new set of x1 in the same cycle -> bit stays 1.
- flush_i while PAIR is stalled -> next cycle EMPTY, issue_v_o=0, scoreboard unchanged. Writes to x0 as long rd -> no bit set and no stall.
- Force stall_cnt_o to 16'hFFFE and hold the stall 3 cycles -> reads 16'hFFFF and stays there. Reset mid-stall -> all outputs return to their reset values.

Source files
------------

// File: rtl/bp_be_dual_issue_sched_if.sv
// Decode-to-scheduler pair bus and the scheduler's issue outputs.
// Handshake: a pair transfers on a rising clock edge where pair_v_i & pair_ready_o;
// pair_v_i and the payload hold steady until that edge; issue_v_o needs no ready.
interface bp_be_dual_issue_sched_if #(
  parameter int instr_width_p    = 32,
  parameter int reg_addr_width_p = 5
);
  logic                                   pair_v_i;
  logic                                   pair_ready_o;
  logic [1:0]                             in_v_i;
  logic [1:0][instr_width_p-1:0]          in_instr_i;
  logic [1:0][reg_addr_width_p-1:0]       in_rs1_i;
  logic [1:0][reg_addr_width_p-1:0]       in_rs2_i;
  logic [1:0]                             in_rs1_r_v_i;
  logic [1:0]                             in_rs2_r_v_i;
  logic [1:0][reg_addr_width_p-1:0]       in_rd_i;
  logic [1:0]                             in_rd_w_v_i;
  logic [1:0]                             in_long_i;
  logic [1:0]                             issue_v_o;
  logic [1:0][instr_width_p-1:0]          issue_instr_o;

  modport master (
    output pair_v_i, in_v_i, in_instr_i, in_rs1_i, in_rs2_i, in_rs1_r_v_i,
           in_rs2_r_v_i, in_rd_i, in_rd_w_v_i, in_long_i,
    input  pair_ready_o, issue_v_o, issue_instr_o
  );

  modport slave (
    input  pair_v_i, in_v_i, in_instr_i, in_rs1_i, in_rs2_i, in_rs1_r_v_i,
           in_rs2_r_v_i, in_rd_i, in_rd_w_v_i, in_long_i,
    output pair_ready_o, issue_v_o, issue_instr_o
  );
endinterface

// File: rtl/bp_be_dual_issue_sched.sv
// In-order dual-issue pairing controller: 2-slot issue buffer plus a pending-register
// scoreboard for long-latency destinations; issues both slots, slot 0 only, or nothing.
module bp_be_dual_issue_sched #(
  parameter int reg_addr_width_gp = 5,
  parameter int instr_width_gp    = 32,
  parameter int stall_cnt_width_p = 16
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              flush_i,
  bp_be_dual_issue_sched_if.slave           pair_if,
  input  logic                              clear_v_i,
  input  logic [reg_addr_width_gp-1:0]      clear_rd_i,
  output logic [stall_cnt_width_p-1:0]      stall_cnt_o,
  output logic [1:0]                        state_o,
  output logic [2**reg_addr_width_gp-1:0]   pending_o
);

  localparam int nregs_lp = 2**reg_addr_width_gp;

  typedef enum logic [1:0] {EMPTY = 2'd0, PAIR = 2'd1, SINGLE = 2'd2} state_e;

  typedef struct packed {
    logic [instr_width_gp-1:0]    instr;
    logic [reg_addr_width_gp-1:0] rs1;
    logic [reg_addr_width_gp-1:0] rs2;
    logic [reg_addr_width_gp-1:0] rd;
    logic                         rs1_v;
    logic                         rs2_v;
    logic                         rd_w_v;
    logic                         long_op;
  } slot_s;

  state_e                         state_q, state_n;
  slot_s [1:0]                    slot_q, in_slot;
  logic [nregs_lp-1:0]            pending_q, pending_n, set_vec, clear_vec;
  logic [stall_cnt_width_p-1:0]   stall_cnt_q;
  logic [1:0]                     issue_v;
  logic                           haz0, haz1, s0_writes, all_issue, accept, load, shift;

  function automatic logic pend_hazard(input slot_s s, input logic [nregs_lp-1:0] p);
    return (s.rs1_v & p[s.rs1]) | (s.rs2_v & p[s.rs2]) | (s.rd_w_v & p[s.rd]);
  endfunction

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      in_slot[s].instr   = pair_if.in_instr_i[s];
      in_slot[s].rs1     = pair_if.in_rs1_i[s];
      in_slot[s].rs2     = pair_if.in_rs2_i[s];
      in_slot[s].rd      = pair_if.in_rd_i[s];
      in_slot[s].rs1_v   = pair_if.in_rs1_r_v_i[s];
      in_slot[s].rs2_v   = pair_if.in_rs2_r_v_i[s];
      in_slot[s].rd_w_v  = pair_if.in_rd_w_v_i[s];
      in_slot[s].long_op = pair_if.in_long_i[s];
    end
  end

  // Hazards read only registered pending bits: a writeback clear is visible next cycle.
  always_comb begin
    s0_writes = slot_q[0].rd_w_v & (slot_q[0].rd != '0);
    haz0      = pend_hazard(slot_q[0], pending_q);
    haz1      = pend_hazard(slot_q[1], pending_q)
              | (s0_writes & slot_q[1].rs1_v & (slot_q[1].rs1 == slot_q[0].rd))
              | (s0_writes & slot_q[1].rs2_v & (slot_q[1].rs2 == slot_q[0].rd))
              | (s0_writes & slot_q[1].rd_w_v & (slot_q[1].rd == slot_q[0].rd))
              | (slot_q[0].long_op & slot_q[1].long_op);
    issue_v[0] = (state_q != EMPTY) & ~reset_i & ~flush_i & ~haz0;
    issue_v[1] = (state_q == PAIR) & issue_v[0] & ~haz1;
    all_issue  = ((state_q == SINGLE) & issue_v[0]) | ((state_q == PAIR) & issue_v[1]);
    pair_if.pair_ready_o = ~reset_i & ~flush_i & ((state_q == EMPTY) | all_issue);
    accept     = pair_if.pair_v_i & pair_if.pair_ready_o;
  end

  assign pair_if.issue_v_o     = issue_v;
  assign pair_if.issue_instr_o = {slot_q[1].instr, slot_q[0].instr};

  always_comb begin
    state_n = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    if (flush_i) begin
      state_n = EMPTY;
    end else if (accept) begin
      state_n = pair_if.in_v_i[1] ? PAIR : SINGLE;
      load    = 1'b1;
    end else begin
      case (state_q)
        PAIR: begin
          if (issue_v[1]) begin
            state_n = EMPTY;
          end else if (issue_v[0]) begin
            state_n = SINGLE;
            shift   = 1'b1;
          end
        end
        SINGLE:  if (issue_v[0]) state_n = EMPTY;
        default: state_n = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= EMPTY;
    else         state_q <= state_n;
  end

  always_ff @(posedge clk_i) begin
    if (load)       slot_q    <= in_slot;
    else if (shift) slot_q[0] <= slot_q[1];
  end

  // Set wins over clear; the WAW rule keeps the two slots from setting the same reg.
  always_comb begin
    set_vec   = '0;
    clear_vec = '0;
    for (int s = 0; s < 2; s++) begin
      if (issue_v[s] & slot_q[s].long_op & slot_q[s].rd_w_v & (slot_q[s].rd != '0))
        set_vec[slot_q[s].rd] = 1'b1;
    end
    if (clear_v_i) clear_vec[clear_rd_i] = 1'b1;
    pending_n = (pending_q & ~clear_vec) | set_vec;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) pending_q <= '0;
    else         pending_q <= pending_n;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)
      stall_cnt_q <= '0;
    else if ((state_q != EMPTY) && (issue_v == 2'b00) && !(&stall_cnt_q))
      stall_cnt_q <= stall_cnt_q + stall_cnt_width_p'(1);
  end

  assign stall_cnt_o = stall_cnt_q;
  assign state_o     = state_q;
  assign pending_o   = pending_q;

endmodule

// File: tb/tb_bp_be_dual_issue_sched.sv
// Scenario bench for bp_be_dual_issue_sched: per-feature tasks with inline checks plus
// an in-order payload scoreboard fed on pair acceptance and drained on issue.
module tb_bp_be_dual_issue_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        clear_v = 1'b0;
  logic [4:0]  clear_rd = '0;
  logic [15:0] stall_cnt;
  logic [1:0]  state;
  logic [31:0] pending;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  localparam logic [1:0] ST_EMPTY = 2'd0, ST_PAIR = 2'd1, ST_SINGLE = 2'd2;

  bp_be_dual_issue_sched_if #(.instr_width_p(32), .reg_addr_width_p(5)) pif ();

  bp_be_dual_issue_sched #(.reg_addr_width_gp(5), .instr_width_gp(32), .stall_cnt_width_p(16)) dut (
    .clk_i(clk), .reset_i(rst), .flush_i(flush), .pair_if(pif),
    .clear_v_i(clear_v), .clear_rd_i(clear_rd),
    .stall_cnt_o(stall_cnt), .state_o(state), .pending_o(pending)
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard: every issued slot must match the oldest accepted payload
  always @(negedge clk) begin
    if (!rst) begin
      for (int s = 0; s < 2; s++) begin
        if (pif.issue_v_o[s]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected slot=%0d got=%h exp=none", s, pif.issue_instr_o[s]);
          end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (pif.issue_instr_o[s] !== e) begin
              errors++;
              $display("FAIL sb_payload slot=%0d got=%h exp=%h", s, pif.issue_instr_o[s], e);
            end
          end
        end
      end
    end
  end

  // driver tasks
  task automatic set_slot(input int s, input logic [4:0] rd, input logic rdv,
                          input logic [4:0] rs1, input logic rs1v,
                          input logic [4:0] rs2, input logic rs2v, input logic lng);
    pif.in_instr_i[s]   = $urandom;
    pif.in_rd_i[s]      = rd;
    pif.in_rd_w_v_i[s]  = rdv;
    pif.in_rs1_i[s]     = rs1;
    pif.in_rs1_r_v_i[s] = rs1v;
    pif.in_rs2_i[s]     = rs2;
    pif.in_rs2_r_v_i[s] = rs2v;
    pif.in_long_i[s]    = lng;
  endtask

  // Holds the pair until accepted; returns at the negedge after the accepting edge.
  task automatic send(input logic [1:0] v);
    bit done;
    done = 1'b0;
    pif.pair_v_i = 1'b1;
    pif.in_v_i   = v;
    for (int i = 0; i < 50 && !done; i++) begin
      #1;
      if (pif.pair_ready_o) begin
        @(posedge clk);
        exp_q.push_back(pif.in_instr_i[0]);
        if (v[1]) exp_q.push_back(pif.in_instr_i[1]);
        done = 1'b1;
      end
      @(negedge clk);
    end
    pif.pair_v_i = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_accept got=no_accept exp=accept_within_50");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (pif.pair_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", pif.pair_ready_o); end
    checks++; if (pif.issue_v_o !== 2'b00) begin errors++; $display("FAIL rst_issue got=%b exp=00", pif.issue_v_o); end
    checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL rst_stall got=%h exp=0", stall_cnt); end
    checks++; if (state !== ST_EMPTY) begin errors++; $display("FAIL rst_state got=%0d exp=0", state); end
    checks++; if (pending !== 32'h0) begin errors++; $display("FAIL rst_pending got=%h exp=0", pending); end
    rst = 1'b0;
    #1;
    checks++; if (pif.pair_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready_after got=%b exp=1", pif.pair_ready_o); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      set_slot(0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
      set_slot(1, 5'd4, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
      send(2'b11);
      checks++; if (pif.issue_v_o !== 2'b11) begin errors++; $display("FAIL b2b_issue k=%0d got=%b exp=11", k, pif.issue_v_o); end
      #1;
      checks++; if (pif.pair_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready k=%0d got=%b exp=1", k, pif.pair_ready_o); end
    end
    @(negedge clk);
    checks++; if (state !== ST_EMPTY || pif.issue_v_o !== 2'b00) begin errors++; $display("FAIL b2b_drain got=%0d/%b exp=0/00", state, pif.issue_v_o); end
  endtask

  task automatic test_intra_raw();
    set_slot(0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    set_slot(1, 5'd7, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0);
    send(2'b11);
    checks++; if (pif.issue_v_o !== 2'b01) begin errors++; $display("FAIL raw_c1_issue got=%b exp=01", pif.issue_v_o); end
    @(negedge clk);
    checks++; if (state !== ST_SINGLE) begin errors++; $display("FAIL raw_state got=%0d exp=2", state); end
    checks++; if (pif.issue_v_o !== 2'b01) begin errors++; $display("FAIL raw_c2_issue got=%b exp=01", pif.issue_v_o); end
    checks++; if (pif.pair_ready_o !== 1'b1) begin errors++; $display("FAIL raw_c2_ready got=%b exp=1", pif.pair_ready_o); end
    @(negedge clk);
    checks++; if (state !== ST_EMPTY) begin errors++; $display("FAIL raw_end_state got=%0d exp=0", state); end
  endtask

  task automatic test_long_stall();
    set_slot(0, 5'd5, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1);
    send(2'b01);
    checks++; if (pif.issue_v_o !== 2'b01) begin errors++; $display("FAIL ld_issue got=%b exp=01", pif.issue_v_o); end
    set_slot(0, 5'd8, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
    set_slot(1, 5'd9, 1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 1'b0);
    send(2'b11);
    for (int c = 0; c < 3; c++) begin
      checks++; if (pif.issue_v_o !== 2'b00) begin errors++; $display("FAIL stall_issue c=%0d got=%b exp=00", c, pif.issue_v_o); end
      checks++; if (stall_cnt !== 16'(c)) begin errors++; $display("FAIL stall_cnt c=%0d got=%0d exp=%0d", c, stall_cnt, c); end
      if (c < 2) @(negedge clk);
    end
    clear_v = 1'b1; clear_rd = 5'd5;
    #1;
    checks++; if (pif.issue_v_o !== 2'b00) begin errors++; $display("FAIL clr_same_cycle got=%b exp=00", pif.issue_v_o); end
    @(negedge clk);
    clear_v = 1'b0;
    checks++; if (pif.issue_v_o !== 2'b11) begin errors++; $display("FAIL clr_next_issue got=%b exp=11", pif.issue_v_o); end
    checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL clr_stall got=%0d exp=3", stall_cnt); end
    @(negedge clk);
    checks++; if (stall_cnt !== 16'd3 || state !== ST_EMPTY) begin errors++; $display("FAIL clr_after got=%0d/%0d exp=3/0", stall_cnt, state); end
  endtask

  task automatic test_two_long();
    set_slot(0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1);
    set_slot(1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b1);
    send(2'b11);
    checks++; if (pif.issue_v_o !== 2'b01) begin errors++; $display("FAIL long2_c1 got=%b exp=01", pif.issue_v_o); end
    @(negedge clk);
    checks++; if (state !== ST_SINGLE || pif.issue_v_o !== 2'b01) begin errors++; $display("FAIL long2_c2 got=%0d/%b exp=2/01", state, pif.issue_v_o); end
    checks++; if (pending !== 32'h2) begin errors++; $display("FAIL long2_pend1 got=%h exp=2", pending); end
    @(negedge clk);
    checks++; if (pending !== 32'h6) begin errors++; $display("FAIL long2_pend12 got=%h exp=6", pending); end
    clear_v = 1'b1; clear_rd = 5'd1;
    @(negedge clk);
    clear_v = 1'b0;
    checks++; if (pending !== 32'h4) begin errors++; $display("FAIL long2_clr1 got=%h exp=4", pending); end
    set_slot(0, 5'd1, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1);
    send(2'b01);
    clear_v = 1'b1; clear_rd = 5'd1;
    #1;
    checks++; if (pif.issue_v_o !== 2'b01) begin errors++; $display("FAIL setclr_issue got=%b exp=01", pif.issue_v_o); end
    @(negedge clk);
    checks++; if (pending !== 32'h6) begin errors++; $display("FAIL set_wins got=%h exp=6", pending); end
    clear_rd = 5'd1;
    @(negedge clk);
    clear_rd = 5'd2;
    @(negedge clk);
    clear_v = 1'b0;
    checks++; if (pending !== 32'h0) begin errors++; $display("FAIL long2_cleanup got=%h exp=0", pending); end
  endtask

  task automatic test_flush();
    set_slot(0, 5'd3, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1);
    send(2'b01);
    set_slot(0, 5'd12, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
    set_slot(1, 5'd13, 1'b1, 5'd14, 1'b1, 5'd15, 1'b1, 1'b0);
    send(2'b11);
    checks++; if (state !== ST_PAIR || pif.issue_v_o !== 2'b00) begin errors++; $display("FAIL fl_stalled got=%0d/%b exp=1/00", state, pif.issue_v_o); end
    flush = 1'b1;
    #1;
    checks++; if (pif.issue_v_o !== 2'b00 || pif.pair_ready_o !== 1'b0) begin errors++; $display("FAIL fl_force got=%b/%b exp=00/0", pif.issue_v_o, pif.pair_ready_o); end
    @(negedge clk);
    flush = 1'b0;
    exp_q.delete();
    checks++; if (state !== ST_EMPTY || pif.issue_v_o !== 2'b00) begin errors++; $display("FAIL fl_empty got=%0d/%b exp=0/00", state, pif.issue_v_o); end
    checks++; if (pending !== 32'h8) begin errors++; $display("FAIL fl_pending got=%h exp=8", pending); end
    checks++; if (stall_cnt !== 16'd4) begin errors++; $display("FAIL fl_stall got=%0d exp=4", stall_cnt); end
    clear_v = 1'b1; clear_rd = 5'd3;
    @(negedge clk);
    clear_v = 1'b0;
  endtask

  task automatic test_x0();
    set_slot(0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1);
    send(2'b01);
    checks++; if (pif.issue_v_o !== 2'b01) begin errors++; $display("FAIL x0_single got=%b exp=01", pif.issue_v_o); end
    set_slot(0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1);
    set_slot(1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
    send(2'b11);
    checks++; if (pif.issue_v_o !== 2'b11) begin errors++; $display("FAIL x0_pair got=%b exp=11", pif.issue_v_o); end
    checks++; if (pending !== 32'h0) begin errors++; $display("FAIL x0_pending got=%h exp=0", pending); end
    @(negedge clk);
    checks++; if (pending !== 32'h0 || stall_cnt !== 16'd4) begin errors++; $display("FAIL x0_after got=%h/%0d exp=0/4", pending, stall_cnt); end
  endtask

  task automatic test_stall_sat_and_reset();
    set_slot(0, 5'd5, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1);
    send(2'b01);
    set_slot(0, 5'd8, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0);
    set_slot(1, 5'd9, 1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 1'b0);
    send(2'b11);
    force dut.stall_cnt_q = 16'hFFFE;
    #1;
    release dut.stall_cnt_q;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat c=%0d got=%h exp=ffff", c, stall_cnt); end
    end
    rst = 1'b1;
    exp_q.delete();
    #1;
    checks++; if (pif.pair_ready_o !== 1'b0 || pif.issue_v_o !== 2'b00) begin errors++; $display("FAIL midrst_during got=%b/%b exp=0/00", pif.pair_ready_o, pif.issue_v_o); end
    @(negedge clk);
    checks++; if (state !== ST_EMPTY || pending !== 32'h0 || stall_cnt !== 16'h0) begin errors++; $display("FAIL midrst_vals got=%0d/%h/%h exp=0/0/0", state, pending, stall_cnt); end
    rst = 1'b0;
    #1;
    checks++; if (pif.pair_ready_o !== 1'b1 || pif.issue_v_o !== 2'b00) begin errors++; $display("FAIL midrst_after got=%b/%b exp=1/00", pif.pair_ready_o, pif.issue_v_o); end
    @(negedge clk);
  endtask

  initial begin
    pif.pair_v_i = 1'b0;
    pif.in_v_i   = 2'b00;
    set_slot(0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    set_slot(1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    test_reset();
    test_back_to_back();
    test_intra_raw();
    test_long_stall();
    test_two_long();
    test_flush();
    test_x0();
    test_stall_sat_and_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
